// File: rtl/memory_port_arbiter_if.sv
// Handshake bundle between the two bytecode requesters, the arbiter and the shared
// memory micro-instruction port. The arbiter connects through the slave modport.
interface memory_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             fetch_start;
  logic [WIDTH-1:0] fetch_instruction;
  logic             fetch_ready;
  logic             dec_start;
  logic [WIDTH-1:0] dec_instruction;
  logic             dec_ready;
  logic             start_for_memory;
  logic [WIDTH-1:0] instruction_for_memory;
  logic             ready_for_memory;
  logic             busy;
  logic             owner;
  logic             timeout_error;

  modport slave (
    input  fetch_start, fetch_instruction, dec_start, dec_instruction, ready_for_memory,
    output fetch_ready, dec_ready, start_for_memory, instruction_for_memory,
           busy, owner, timeout_error
  );

  modport master (
    output fetch_start, fetch_instruction, dec_start, dec_instruction, ready_for_memory,
    input  fetch_ready, dec_ready, start_for_memory, instruction_for_memory,
           busy, owner, timeout_error
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory micro-instruction port between fetch (0) and
// decoder (1), with a watchdog that completes a transaction the memory never answers.
module memory_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  memory_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RESP
  } state_t;

  localparam bit               WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               pick;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    // On a tie the requester that was not served last wins.
    pick         = (bus.fetch_start && bus.dec_start) ? ~last_owner_q : bus.dec_start;

    unique case (state_q)
      IDLE: begin
        if (bus.fetch_start || bus.dec_start) begin
          instr_d = pick ? bus.dec_instruction : bus.fetch_instruction;
          owner_d = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A memory answer on the watchdog's last cycle still counts as a completion.
        if (bus.ready_for_memory) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (WD_EN && cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign bus.start_for_memory       = (state_q == GRANT);
  assign bus.instruction_for_memory = instr_q;
  assign bus.fetch_ready            = (state_q == RESP) && !owner_q;
  assign bus.dec_ready              = (state_q == RESP) &&  owner_q;
  assign bus.busy                   = (state_q != IDLE);
  assign bus.owner                  = owner_q;
  assign bus.timeout_error          = err_q;

endmodule
